// File: rtl/cmult_shift_sat.sv
`default_nettype none
// ============================================================================
//  Module   : cmult_shift_sat
//  Purpose  : Back-pressured complex multiply (a*b or a*conj(b)) followed by
//             a per-beat left shift, truncation (or rounding) to OUT_W, and
//             saturation with overflow pulse / sticky flag / event counter.
//             Three register stages: operands, partial products, output.
//  Options  : define CMS_ROUND_EN to round half up instead of truncating.
//  Revision : 1.0  initial release
// ============================================================================
module cmult_shift_sat #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 conj_b,
  input  logic [2*IN_W-1:0]    s_a_tdata,
  input  logic                 s_a_tvalid,
  output logic                 s_a_tready,
  input  logic                 s_a_tlast,
  input  logic [2*IN_W-1:0]    s_b_tdata,
  input  logic                 s_b_tvalid,
  output logic                 s_b_tready,
  output logic [2*OUT_W-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic                 ovf_pulse,
  output logic                 ovf_sticky,
  input  logic                 ovf_clear,
  output logic [CNT_W-1:0]     ovf_count
);

  localparam int c_PROD_W = 2*IN_W;
  localparam int c_P      = 2*IN_W + 1;
  // One guard bit above the P+2**SHIFT_W-1 working width keeps the rounding
  // add from wrapping for any parameter set; results are unaffected.
  localparam int c_EXT_W  = c_P + 2**SHIFT_W;
  localparam int c_DROP   = c_P - OUT_W;
  localparam logic [OUT_W-1:0] c_MAX     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] c_MIN     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Output-side registers
  logic                 r_m_tvalid;
  logic [2*OUT_W-1:0]   r_m_tdata;
  logic                 r_m_tlast;
  logic                 r_ovf_pulse;
  logic                 r_ovf_sticky;
  logic [CNT_W-1:0]     r_ovf_count;

  // Stage 1: operands and per-beat controls
  logic                 r1_valid;
  logic signed [IN_W-1:0] r1_ar, r1_ai, r1_br, r1_bi;
  logic [SHIFT_W-1:0]   r1_shift;
  logic                 r1_conj;
  logic                 r1_last;

  // Stage 2: partial products
  logic                 r2_valid;
  logic signed [c_PROD_W-1:0] r2_rr, r2_ii, r2_ri, r2_ir;
  logic [SHIFT_W-1:0]   r2_shift;
  logic                 r2_conj;
  logic                 r2_last;

  logic w_en;
  logic w_hs;

  // Whole pipeline advances only when the output register can accept data.
  assign w_en       = !r_m_tvalid || m_tready;
  assign w_hs       = w_en && s_a_tvalid && s_b_tvalid;
  assign s_a_tready = w_hs;
  assign s_b_tready = w_hs;

  // Stage 1 valid: set by a joined handshake, cleared on reset.
  always_ff @(posedge aclk) begin
    if (!aresetn)  r1_valid <= 1'b0;
    else if (w_en) r1_valid <= w_hs;
  end

  // Stage 1 data: capture both operands and the controls of the accepted beat.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      r1_ar    <= s_a_tdata[IN_W-1:0];
      r1_ai    <= s_a_tdata[2*IN_W-1:IN_W];
      r1_br    <= s_b_tdata[IN_W-1:0];
      r1_bi    <= s_b_tdata[2*IN_W-1:IN_W];
      r1_shift <= shift;
      r1_conj  <= conj_b;
      r1_last  <= s_a_tlast;
    end
  end

  // Stage 2 valid follows stage 1 whenever the pipeline moves.
  always_ff @(posedge aclk) begin
    if (!aresetn)  r2_valid <= 1'b0;
    else if (w_en) r2_valid <= r1_valid;
  end

  // Stage 2 data: the four signed partial products.
  always_ff @(posedge aclk) begin
    if (w_en && r1_valid) begin
      r2_rr    <= c_PROD_W'(r1_ar) * c_PROD_W'(r1_br);
      r2_ii    <= c_PROD_W'(r1_ai) * c_PROD_W'(r1_bi);
      r2_ri    <= c_PROD_W'(r1_ar) * c_PROD_W'(r1_bi);
      r2_ir    <= c_PROD_W'(r1_ai) * c_PROD_W'(r1_br);
      r2_shift <= r1_shift;
      r2_conj  <= r1_conj;
      r2_last  <= r1_last;
    end
  end

  // Stage 3 arithmetic
  logic signed [c_P-1:0]     w_rr_x, w_ii_x, w_ri_x, w_ir_x;
  logic signed [c_P-1:0]     w_re, w_im;
  logic signed [c_EXT_W-1:0] w_re_sh, w_im_sh;
  logic signed [c_EXT_W-1:0] w_re_rnd, w_im_rnd;
  logic signed [c_EXT_W-1:0] w_re_q, w_im_q;
  logic                      w_re_ovf, w_im_ovf;
  logic [OUT_W-1:0]          w_re_out, w_im_out;
  logic                      w_ovf_evt;

  assign w_rr_x = {r2_rr[c_PROD_W-1], r2_rr};
  assign w_ii_x = {r2_ii[c_PROD_W-1], r2_ii};
  assign w_ri_x = {r2_ri[c_PROD_W-1], r2_ri};
  assign w_ir_x = {r2_ir[c_PROD_W-1], r2_ir};

  // Combine partial products for a*b or a*conj(b).
  always_comb begin
    if (r2_conj) begin
      w_re = w_rr_x + w_ii_x;
      w_im = w_ir_x - w_ri_x;
    end else begin
      w_re = w_rr_x - w_ii_x;
      w_im = w_ri_x + w_ir_x;
    end
  end

  assign w_re_sh = {{(c_EXT_W-c_P){w_re[c_P-1]}}, w_re} << r2_shift;
  assign w_im_sh = {{(c_EXT_W-c_P){w_im[c_P-1]}}, w_im} << r2_shift;

`ifdef CMS_ROUND_EN
  localparam logic [c_EXT_W-1:0] c_RND = {{(c_EXT_W-1){1'b0}}, 1'b1} << (c_DROP-1);
  assign w_re_rnd = w_re_sh + c_RND;
  assign w_im_rnd = w_im_sh + c_RND;
`else
  assign w_re_rnd = w_re_sh;
  assign w_im_rnd = w_im_sh;
`endif

  // After dropping DROP bits, the value fits OUT_W exactly when every bit
  // from OUT_W-1 upward matches the sign (same as the P-bit range test).
  assign w_re_q   = w_re_rnd >>> c_DROP;
  assign w_im_q   = w_im_rnd >>> c_DROP;
  assign w_re_ovf = !((&w_re_q[c_EXT_W-1:OUT_W-1]) || !(|w_re_q[c_EXT_W-1:OUT_W-1]));
  assign w_im_ovf = !((&w_im_q[c_EXT_W-1:OUT_W-1]) || !(|w_im_q[c_EXT_W-1:OUT_W-1]));
  assign w_re_out = w_re_ovf ? (w_re_q[c_EXT_W-1] ? c_MIN : c_MAX) : w_re_q[OUT_W-1:0];
  assign w_im_out = w_im_ovf ? (w_im_q[c_EXT_W-1] ? c_MIN : c_MAX) : w_im_q[OUT_W-1:0];
  assign w_ovf_evt = w_en && r2_valid && (w_re_ovf || w_im_ovf);

  // Output register: holds under back-pressure, loads a beat when S3 is valid.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_en) begin
      r_m_tvalid <= r2_valid;
      if (r2_valid) begin
        r_m_tdata <= {w_im_out, w_re_out};
        r_m_tlast <= r2_last;
      end
    end
  end

  // Overflow tracking: clear takes effect first, then the current event.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ovf_pulse  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_ovf_count  <= '0;
    end else begin
      r_ovf_pulse <= w_ovf_evt;
      if (ovf_clear) begin
        r_ovf_sticky <= w_ovf_evt;
        r_ovf_count  <= w_ovf_evt ? c_CNT_ONE : '0;
      end else if (w_ovf_evt) begin
        r_ovf_sticky <= 1'b1;
        if (r_ovf_count != '1) r_ovf_count <= r_ovf_count + c_CNT_ONE;
      end
    end
  end

  assign m_tvalid   = r_m_tvalid;
  assign m_tdata    = r_m_tdata;
  assign m_tlast    = r_m_tlast;
  assign ovf_pulse  = r_ovf_pulse;
  assign ovf_sticky = r_ovf_sticky;
  assign ovf_count  = r_ovf_count;

endmodule
`default_nettype wire

// File: doc/cmult_shift_sat.md
Name: cmult_shift_sat

Overview:
Parametrised, fully back-pressured complex multiply / scale / saturate stage for the FFT-correlation datapath. It sits between the two forward-FFT outputs and the IFFT input. It joins two AXI-Stream operands and computes a*b or a*conj(b). It then left-shifts by a per-sample scale, truncates or rounds to OUT_W, saturates, and tracks overflow with a sticky flag and a counter. It replaces the fixed 16-bit, IP-based, no-backpressure multiplier with an in-fabric 3-stage pipeline.

Parameters:
IN_W, 16, signed width of each input re/im component
OUT_W, 16, signed width of each output re/im component (OUT_W <= 2*IN_W)
SHIFT_W, 4, width of shift control; shift range 0..2**SHIFT_W-1
CNT_W, 16, width of overflow event counter

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
shift  in  SHIFT_W  left-shift amount, sampled per accepted input beat
conj_b  in  1  1: a*conj(b); 0: a*b; sampled per accepted input beat
s_a_tdata  in  2*IN_W  operand a {im,re}
s_a_tvalid  in  1  operand a valid
s_a_tready  out  1  operand a ready
s_a_tlast  in  1  frame end marker (passed through)
s_b_tdata  in  2*IN_W  operand b {im,re}
s_b_tvalid  in  1  operand b valid
s_b_tready  out  1  operand b ready
m_tdata  out  2*OUT_W  result {im,re}
m_tvalid  out  1  result valid
m_tready  in  1  downstream ready
m_tlast  out  1  registered copy of s_a_tlast
ovf_pulse  out  1  one-cycle flag: saturated beat loaded into output register
ovf_sticky  out  1  set on any saturation, held until ovf_clear
ovf_clear  in  1  synchronous clear of ovf_sticky and ovf_count
ovf_count  out  CNT_W  number of saturated beats, saturating at all-ones

Behaviour:
- Reset (aresetn=0 at a clock edge): m_tvalid=0, m_tdata=0, m_tlast=0, ovf_pulse=0, ovf_sticky=0, ovf_count=0, all internal stage valids=0. Reset mid-frame discards in-flight beats.
- Global enable: en = !m_tvalid || m_tready. When en=0 every stage holds, so m_tdata, m_tvalid and m_tlast stay stable under stall.
- Input join: s_a_tready = s_b_tready = en && s_a_tvalid && s_b_tvalid. Both operands are consumed in the same cycle, never one alone.
- Stage S1: register a, b, shift, conj_b, tlast.
- Stage S2: register the four signed IN_W x IN_W partial products.
- Stage S3: arithmetic, then load the output register. Latency is 3 cycles from the input handshake to m_tvalid when unstalled. Throughput is 1 beat/cycle.
- Arithmetic, with P = 2*IN_W+1:
  - conj_b=0: re = ar*br - ai*bi; im = ar*bi + ai*br.
  - conj_b=1: re = ar*br + ai*bi; im = ai*br - ar*bi.
  - Compute each component in P bits, then sign-extend to P+2**SHIFT_W-1 bits and left-shift by shift.
- Saturation: a component overflows if the shifted value lies outside [-2**(P-1), 2**(P-1)-1].
  - Overflowed component: output is 2**(OUT_W-1)-1 if positive, -2**(OUT_W-1) if negative.
  - Otherwise: output is shifted[P-1 : P-OUT_W], i.e. truncation toward -inf by DROP = P-OUT_W bits.
  - re and im saturate independently.
- Overflow tracking, on each beat loaded into the output register (en=1 and S3 valid):
  - ovf_pulse = (re overflowed | im overflowed). ovf_pulse is 0 on all other cycles.
  - On ovf_pulse: ovf_sticky <= 1, and ovf_count increments unless it is at all-ones.
  - ovf_clear in the same cycle as ovf_pulse: clear applies first, then the event, giving sticky=1 and count=1.
- Changing shift or conj_b between beats affects only later-accepted beats.

Optional Feature:
- Macro CMS_ROUND_EN. When defined, add 2**(DROP-1) to the shifted value before truncation (round half up).
- The saturation check is applied after the rounding add, so a rounding carry past the max saturates and flags overflow.
- When undefined, plain truncation as above.

Test Plan:
- IN_W=OUT_W=16, shift=0, conj_b=0, a=1000+2000j, b=3000-4000j -> after 3 cycles m_tdata re=83, im=15, ovf_pulse=0.
- Same operands, shift=4 -> re=1342, im=244. With CMS_ROUND_EN -> re=1343, im=244. With shift=0 and CMS_ROUND_EN -> re=84, im=15.
- a=b=-32768+0j: shift=1 -> re=16384, im=0. Shift=2 -> re=32767, ovf_pulse=1, ovf_sticky=1, ovf_count=1. Then ovf_clear -> sticky=0, count=0.
- a=b=0+16384j: conj_b=1 -> re=2048, im=0; conj_b=0 -> re=-2048, im=0. Drive re product -196608 (a=-384+0j, b=512+0j): truncate -> -2, CMS_ROUND_EN -> -1.
- 16-beat frame with s_a_tlast on beat 16 and random m_tready (including 10 consecutive low cycles):
  - all 16 results arrive in order with m_tlast only on the last beat;
  - m_tdata is stable while m_tvalid=1 and m_tready=0;
  - input readys go low while stalled.
- s_a_tvalid=1 with s_b_tvalid=0 -> both readys 0, no beat consumed. Assert aresetn=0 with 2 beats in flight -> m_tvalid=0 the next cycle, and no stale beat emerges afterwards.
